// File: rtl/riscv_multiciclo.sv
`default_nettype none
// ============================================================================
// Module   : riscv_multiciclo
// Purpose  : Multi-cycle RV32I-subset core. It shares one ALU and one unified
//            instruction/data memory port across the FETCH, DECODE, EXEC,
//            MEM, WB and HALT states. The memory port uses a req/ready
//            handshake, so the core tolerates wait states.
// Ports    : clk, reset (async, active-high)
//            mem_req/mem_we/mem_addr/mem_wdata -> memory request
//            mem_rdata/mem_ready               <- memory response
//            pc_o, instr_o, instret_o, halted_o -> debug and status
// Options  : RISCV_MC_HALT_ON_ILLEGAL_EN - when defined, an illegal
//            instruction halts the core until reset. Otherwise an illegal
//            instruction retires as a NOP.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_multiciclo #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NUM_REGS = 32,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       pc_o,
  output logic [31:0]       instr_o,
  output logic [31:0]       instret_o,
  output logic              halted_o
);

  localparam int RIDX_W = (NUM_REGS == 16) ? 4 : 5;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] imm_q, imm_d;
  logic [31:0] alu_out_q, alu_out_d;
  logic [31:0] mdr_q, mdr_d;
  logic [31:0] instret_q, instret_d;
  logic [31:0] regs_q [NUM_REGS];
  logic [31:0] regs_d [NUM_REGS];

  // --------------------------------------------------------------------------
  // Instruction decode (IR is stable from DECODE through WB)
  // --------------------------------------------------------------------------
  logic [6:0] w_opcode;
  logic [4:0] w_rd, w_rs1, w_rs2;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;

  assign w_opcode = ir_q[6:0];
  assign w_rd     = ir_q[11:7];
  assign w_funct3 = ir_q[14:12];
  assign w_rs1    = ir_q[19:15];
  assign w_rs2    = ir_q[24:20];
  assign w_funct7 = ir_q[31:25];

  logic w_alu_f3;
  assign w_alu_f3 = (w_funct3 == 3'b000) || (w_funct3 == 3'b111) ||
                    (w_funct3 == 3'b110) || (w_funct3 == 3'b010);

  logic w_is_r, w_is_i, w_is_lw, w_is_sw, w_is_br, w_is_jal;
  assign w_is_r   = (w_opcode == 7'b0110011) &&
                    (((w_funct7 == 7'b0000000) && w_alu_f3) ||
                     ((w_funct7 == 7'b0100000) && (w_funct3 == 3'b000)));
  assign w_is_i   = (w_opcode == 7'b0010011) && w_alu_f3;
  assign w_is_lw  = (w_opcode == 7'b0000011) && (w_funct3 == 3'b010);
  assign w_is_sw  = (w_opcode == 7'b0100011) && (w_funct3 == 3'b010);
  assign w_is_br  = (w_opcode == 7'b1100011) && (w_funct3[2:1] == 2'b00);
  assign w_is_jal = (w_opcode == 7'b1101111);

  // Only the register fields an instruction format actually uses are checked;
  // for I-type the rs2 field is immediate bits.
  logic w_uses_rs1, w_uses_rs2, w_uses_rd;
  assign w_uses_rs1 = w_is_r | w_is_i | w_is_lw | w_is_sw | w_is_br;
  assign w_uses_rs2 = w_is_r | w_is_sw | w_is_br;
  assign w_uses_rd  = w_is_r | w_is_i | w_is_lw | w_is_jal;

  logic w_rs1_oor, w_rs2_oor, w_rd_oor;
  generate
    if (NUM_REGS == 16) begin : g_rv32e
      assign w_rs1_oor = w_rs1[4];
      assign w_rs2_oor = w_rs2[4];
      assign w_rd_oor  = w_rd[4];
    end else begin : g_rv32i
      assign w_rs1_oor = 1'b0;
      assign w_rs2_oor = 1'b0;
      assign w_rd_oor  = 1'b0;
    end
  endgenerate

  logic w_legal;
  assign w_legal = (w_is_r | w_is_i | w_is_lw | w_is_sw | w_is_br | w_is_jal) &&
                   !(w_uses_rs1 && w_rs1_oor) &&
                   !(w_uses_rs2 && w_rs2_oor) &&
                   !(w_uses_rd  && w_rd_oor);

  // Immediate formats, sign-extended
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_j, w_imm;
  assign w_imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
  assign w_imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign w_imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign w_imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

  always_comb begin
    w_imm = w_imm_i;
    if (w_is_sw)       w_imm = w_imm_s;
    else if (w_is_br)  w_imm = w_imm_b;
    else if (w_is_jal) w_imm = w_imm_j;
  end

  // Register file read ports; x0 is forced to zero on read as well
  logic [31:0] w_rf_rs1, w_rf_rs2;
  assign w_rf_rs1 = (w_rs1 == 5'd0) ? 32'd0 : regs_q[w_rs1[RIDX_W-1:0]];
  assign w_rf_rs2 = (w_rs2 == 5'd0) ? 32'd0 : regs_q[w_rs2[RIDX_W-1:0]];

  // --------------------------------------------------------------------------
  // ALU for R/I operations (second operand is B for R-type, imm for I-type)
  // --------------------------------------------------------------------------
  logic [31:0] w_op2, w_alu_res;
  assign w_op2 = w_is_r ? b_q : imm_q;

  always_comb begin
    w_alu_res = a_q + w_op2;
    case (w_funct3)
      3'b000:  w_alu_res = (w_is_r && w_funct7[5]) ? (a_q - w_op2) : (a_q + w_op2);
      3'b111:  w_alu_res = a_q & w_op2;
      3'b110:  w_alu_res = a_q | w_op2;
      3'b010:  w_alu_res = {31'd0, ($signed(a_q) < $signed(w_op2))};
      default: w_alu_res = a_q + w_op2;
    endcase
  end

  logic w_br_taken;
  assign w_br_taken = w_funct3[0] ? (a_q != b_q) : (a_q == b_q);

`ifdef RISCV_MC_HALT_ON_ILLEGAL_EN
  logic halted_q, halted_d;
`endif

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  logic              w_retire;
  logic              w_rf_we;
  logic [RIDX_W-1:0] w_rf_waddr;
  logic [31:0]       w_rf_wdata;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    a_d        = a_q;
    b_d        = b_q;
    imm_d      = imm_q;
    alu_out_d  = alu_out_q;
    mdr_d      = mdr_q;
    w_retire   = 1'b0;
    w_rf_we    = 1'b0;
    w_rf_waddr = w_rd[RIDX_W-1:0];
    w_rf_wdata = 32'd0;
`ifdef RISCV_MC_HALT_ON_ILLEGAL_EN
    halted_d   = halted_q;
`endif

    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + 32'd4;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        a_d       = w_rf_rs1;
        b_d       = w_rf_rs2;
        imm_d     = w_imm;
        // PC already points past this instruction, so step back one word
        alu_out_d = (pc_q - 32'd4) + w_imm;
        if (!w_legal) begin
`ifdef RISCV_MC_HALT_ON_ILLEGAL_EN
          halted_d = 1'b1;
          state_d  = S_HALT;
`else
          w_retire = 1'b1;
          state_d  = S_FETCH;
`endif
        end else if (w_is_jal) begin
          w_rf_we    = 1'b1;
          w_rf_wdata = pc_q;
          pc_d       = alu_out_d & ~32'd3;
          w_retire   = 1'b1;
          state_d    = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        if (w_is_r || w_is_i) begin
          alu_out_d = w_alu_res;
          state_d   = S_WB;
        end else if (w_is_lw || w_is_sw) begin
          alu_out_d = a_q + imm_q;
          state_d   = S_MEM;
        end else begin
          // Branch: the target was computed into ALUOut during DECODE
          if (w_is_br && w_br_taken) pc_d = alu_out_q & ~32'd3;
          w_retire = 1'b1;
          state_d  = S_FETCH;
        end
      end

      S_MEM: begin
        if (mem_ready) begin
          if (w_is_sw) begin
            w_retire = 1'b1;
            state_d  = S_FETCH;
          end else begin
            mdr_d   = mem_rdata;
            state_d = S_WB;
          end
        end
      end

      S_WB: begin
        w_rf_we    = 1'b1;
        w_rf_wdata = w_is_lw ? mdr_q : alu_out_q;
        w_retire   = 1'b1;
        state_d    = S_FETCH;
      end

      S_HALT: state_d = S_HALT;

      default: state_d = S_FETCH;
    endcase

    instret_d = w_retire ? (instret_q + 32'd1) : instret_q;

    regs_d = regs_q;
    if (w_rf_we && (w_rf_waddr != '0)) regs_d[w_rf_waddr] = w_rf_wdata;
  end

  // --------------------------------------------------------------------------
  // Sequential state
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      imm_q     <= '0;
      alu_out_q <= '0;
      mdr_q     <= '0;
      instret_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
`ifdef RISCV_MC_HALT_ON_ILLEGAL_EN
      halted_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      imm_q     <= imm_d;
      alu_out_q <= alu_out_d;
      mdr_q     <= mdr_d;
      instret_q <= instret_d;
      regs_q    <= regs_d;
`ifdef RISCV_MC_HALT_ON_ILLEGAL_EN
      halted_q  <= halted_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. Request strobes are masked by reset so an access in flight is
  // dropped in the same cycle reset rises, not at the next edge.
  // --------------------------------------------------------------------------
  assign mem_req   = !reset && ((state_q == S_FETCH) || (state_q == S_MEM));
  assign mem_we    = !reset && (state_q == S_MEM) && w_is_sw;
  assign mem_addr  = (state_q == S_MEM) ? {alu_out_q[ADDR_W-1:2], 2'b00}
                                        : {pc_q[ADDR_W-1:2], 2'b00};
  assign mem_wdata = mem_we ? b_q : 32'd0;

  assign pc_o      = pc_q;
  assign instr_o   = ir_q;
  assign instret_o = instret_q;

`ifdef RISCV_MC_HALT_ON_ILLEGAL_EN
  assign halted_o = halted_q;
`else
  assign halted_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_riscv_multiciclo.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_multiciclo
// Purpose  : Directed self-checking bench for riscv_multiciclo. Instance dut0
//            uses the default configuration (RESET_PC 0, 32 registers).
//            Instance dut1 uses RESET_PC 0x100 and 16 registers. Both
//            instances share one word-addressed memory model. Each instance
//            has its own programmable wait-state count.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_multiciclo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1;
  logic req0, we0, ready0, halt0;
  logic req1, we1, ready1, halt1;
  logic [31:0] addr0, wdata0, rdata0, pc0, ir0, ret0;
  logic [31:0] addr1, wdata1, rdata1, pc1, ir1, ret1;

  int wait0 = 0, wait1 = 0, cnt0 = 0, cnt1 = 0;
  logic [31:0] mem [256];
  logic [31:0] last_waddr = '0, last_wdata = '0;

  int n_tests = 0;
  int n_fail  = 0;

  riscv_multiciclo #(.RESET_PC(32'h0000_0000), .NUM_REGS(32), .ADDR_W(32)) dut0 (
    .clk(clk), .reset(rst0), .mem_req(req0), .mem_we(we0), .mem_addr(addr0),
    .mem_wdata(wdata0), .mem_rdata(rdata0), .mem_ready(ready0),
    .pc_o(pc0), .instr_o(ir0), .instret_o(ret0), .halted_o(halt0)
  );

  riscv_multiciclo #(.RESET_PC(32'h0000_0100), .NUM_REGS(16), .ADDR_W(32)) dut1 (
    .clk(clk), .reset(rst1), .mem_req(req1), .mem_we(we1), .mem_addr(addr1),
    .mem_wdata(wdata1), .mem_rdata(rdata1), .mem_ready(ready1),
    .pc_o(pc1), .instr_o(ir1), .instret_o(ret1), .halted_o(halt1)
  );

  // Memory model: ready is combinational once the wait count is reached
  assign rdata0 = mem[addr0[9:2]];
  assign rdata1 = mem[addr1[9:2]];
  assign ready0 = req0 && (cnt0 == wait0);
  assign ready1 = req1 && (cnt1 == wait1);

  always @(posedge clk) begin
    cnt0 <= (req0 && !ready0) ? cnt0 + 1 : 0;
    cnt1 <= (req1 && !ready1) ? cnt1 + 1 : 0;
    if (req0 && we0 && ready0) begin
      mem[addr0[9:2]] <= wdata0;
      last_waddr      <= addr0;
      last_wdata      <= wdata0;
    end
    if (req1 && we1 && ready1) begin
      mem[addr1[9:2]] <= wdata1;
      last_waddr      <= addr1;
      last_wdata      <= wdata1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Step cycles until the selected core's instret reaches target (bounded)
  task automatic wait_ret(input bit which, input logic [31:0] target, input int maxc,
                          input string tag, output int cyc);
    cyc = 0;
    while (((which ? ret1 : ret0) !== target) && (cyc < maxc)) begin
      @(posedge clk); #1;
      cyc++;
    end
    check(tag, which ? ret1 : ret0, target);
  endtask

  initial begin
    int cyc;
    int found;
    int req_seen;

    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    // dut0 program at 0x000
    mem[0]  = 32'h00500093;  // addi x1,x0,5
    mem[1]  = 32'h00700113;  // addi x2,x0,7
    mem[2]  = 32'h002081B3;  // add  x3,x1,x2
    mem[3]  = 32'h40208233;  // sub  x4,x1,x2
    mem[4]  = 32'h00302423;  // sw   x3,8(x0)
    mem[5]  = 32'h00802283;  // lw   x5,8(x0)
    mem[6]  = 32'h00108463;  // beq  x1,x1,+8
    mem[7]  = 32'h00100393;  // addi x7,x0,1   (skipped)
    mem[8]  = 32'h00109463;  // bne  x1,x1,+8  (not taken)
    mem[9]  = 32'h00C0036F;  // jal  x6,+12
    mem[10] = 32'h00200393;  // addi x7,x0,2   (skipped)
    mem[11] = 32'h00300393;  // addi x7,x0,3   (skipped)
    mem[12] = 32'h00900013;  // addi x0,x0,9
    mem[13] = 32'h0000006F;  // jal  x0,0
    // dut1 program at 0x100
    mem[64] = 32'h00500093;  // addi x1,x0,5
    mem[65] = 32'h30002103;  // lw   x2,0x300(x0)
    mem[66] = 32'h002088B3;  // add  x17,x1,x2 (illegal with 16 regs)
    mem[67] = 32'h0000006F;  // jal  x0,0
    mem[192] = 32'hDEADBEEF;

    rst0 = 1'b1;
    rst1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req0",   {31'd0, req0},   32'd0);
    check("rst_we0",    {31'd0, we0},    32'd0);
    check("rst_wdata0", wdata0,          32'd0);
    check("rst_pc0",    pc0,             32'h0);
    check("rst_ir0",    ir0,             32'h0);
    check("rst_ret0",   ret0,            32'd0);
    check("rst_halt0",  {31'd0, halt0},  32'd0);
    check("rst_pc1",    pc1,             32'h100);

    // ---- Basic ALU sequence with zero-wait memory ----
    rst0 = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check("ret_after15", ret0, 32'd3);
    @(posedge clk); #1;
    check("ret_after16", ret0, 32'd4);
    check("x1", dut0.regs_q[1], 32'd5);
    check("x2", dut0.regs_q[2], 32'd7);
    check("x3_add", dut0.regs_q[3], 32'd12);
    check("x4_sub", dut0.regs_q[4], 32'hFFFF_FFFE);

    // ---- Store / load with 3 wait cycles per access ----
    wait0 = 3;
    wait_ret(1'b0, 32'd5, 40, "sw_retire", cyc);
    check("sw_cycles", cyc, 32'd10);
    check("sw_addr",   last_waddr, 32'd8);
    check("sw_data",   last_wdata, 32'd12);
    wait_ret(1'b0, 32'd6, 40, "lw_retire", cyc);
    check("lw_cycles", cyc, 32'd11);
    check("x5_lw", dut0.regs_q[5], 32'd12);

    // ---- Branches and jump ----
    wait0 = 0;
    wait_ret(1'b0, 32'd7, 10, "beq_retire", cyc);
    check("beq_cycles", cyc, 32'd3);
    check("beq_pc",     pc0, 32'd32);
    wait_ret(1'b0, 32'd8, 10, "bne_retire", cyc);
    check("bne_pc",     pc0, 32'd36);
    wait_ret(1'b0, 32'd9, 10, "jal_retire", cyc);
    check("jal_cycles", cyc, 32'd2);
    check("jal_pc",     pc0, 32'd48);
    check("x6_link",    dut0.regs_q[6], 32'd40);
    wait_ret(1'b0, 32'd10, 10, "addi_x0_retire", cyc);
    check("x0_zero",    dut0.regs_q[0], 32'd0);
    check("x7_skipped", dut0.regs_q[7], 32'd0);
    wait_ret(1'b0, 32'd11, 10, "loop_retire", cyc);
    check("loop_pc",    pc0, 32'd52);

    // ---- Retired-instruction counter wrap ----
    force dut0.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut0.instret_q;
    #1;
    check("ret_forced", ret0, 32'hFFFF_FFFF);
    wait_ret(1'b0, 32'd0, 6, "ret_wrap", cyc);
    check("wrap_cycles", cyc, 32'd2);
    rst0 = 1'b1;

    // ---- Async reset in the middle of a MEM access (dut1) ----
    wait1 = 3;
    rst1  = 1'b0;
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      @(posedge clk); #1;
      if (req1 && addr1 == 32'h300) found = 1;
    end
    check("mem_phase_found", found, 32'd1);
    check("mem_phase_ready", {31'd0, ready1}, 32'd0);
    check("mem_phase_we",    {31'd0, we1},    32'd0);
    check("mem_phase_ret",   ret1,            32'd1);
    rst1 = 1'b1;
    #1;
    check("arst_req", {31'd0, req1}, 32'd0);
    check("arst_pc",  pc1,  32'h100);
    check("arst_ret", ret1, 32'd0);
    @(posedge clk); #1;
    wait1 = 0;
    rst1  = 1'b0;

    // ---- Illegal instruction with 16 registers ----
    wait_ret(1'b1, 32'd1, 10, "e_addi_retire", cyc);
    check("e_addi_cycles", cyc, 32'd4);
    wait_ret(1'b1, 32'd2, 10, "e_lw_retire", cyc);
    check("e_lw_cycles", cyc, 32'd5);
    check("e_x2_lw", dut1.regs_q[2], 32'hDEAD_BEEF);
`ifdef RISCV_MC_HALT_ON_ILLEGAL_EN
    repeat (2) @(posedge clk);
    #1;
    check("ill_halted", {31'd0, halt1}, 32'd1);
    check("ill_pc",     pc1,  32'h10C);
    req_seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (req1) req_seen++;
      @(posedge clk); #1;
    end
    check("ill_no_req", req_seen, 32'd0);
    check("ill_ret",    ret1, 32'd2);
    check("ill_x1",     dut1.regs_q[1], 32'd5);
`else
    req_seen = 0;
    wait_ret(1'b1, 32'd3, 10, "ill_nop_retire", cyc);
    check("ill_nop_cycles", cyc, 32'd2);
    check("ill_pc",         pc1, 32'h10C);
    check("ill_halted",     {31'd0, halt1}, 32'd0);
    check("ill_x1",         dut1.regs_q[1], 32'd5);
    check("ill_req_seen",   req_seen, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/riscv_multiciclo.md
Name: riscv_multiciclo

Overview:
- Multi-cycle RV32I-subset core. It is the parametrised successor to the single-cycle `riscv` top.
- One ALU and one unified instruction/data memory port are reused across FSM states. The port has a req/ready handshake, so the core tolerates wait states.
- Register-file size and reset vector are configurable. A retired-instruction counter and debug PC/IR outputs are provided.
- Sits at SoC top level and connects to a single external memory/bus slave.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NUM_REGS, 32, architectural register count; legal values 16 (RV32E) or 32.
- ADDR_W, 32, width of mem_addr; upper PC/ALU bits beyond ADDR_W are dropped.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_req  out  1  memory access request.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req = 1.
- mem_addr  out  ADDR_W  word-aligned byte address; bits [1:0] are always 0.
- mem_wdata  out  32  store data.
- mem_rdata  in  32  read data; valid in the cycle mem_ready = 1.
- mem_ready  in  1  access complete; may be combinational from mem_req.
- pc_o  out  32  current PC (debug).
- instr_o  out  32  instruction register (debug).
- instret_o  out  32  retired-instruction count.
- halted_o  out  1  core halted (only meaningful with the optional feature).

Behaviour:
- Reset (async, takes effect immediately, including mid-access):
  - PC = RESET_PC; IR = 0; state = FETCH; instret_o = 0; halted_o = 0; all registers = 0.
  - mem_req, mem_we and mem_wdata drop to 0 combinationally.
  - The first FETCH request is issued in the first cycle after reset deasserts.
- Supported ops:
  - R: add, sub, and, or, slt.
  - I: addi, andi, ori, slti, lw.
  - S: sw.
  - B: beq, bne.
  - J: jal.
  - All other opcodes, or any rs1/rs2/rd >= NUM_REGS, are illegal.
- FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH:
  - mem_req = 1, mem_we = 0, mem_addr = PC.
  - Request and address are held stable until mem_ready = 1.
  - On ready: IR <= mem_rdata, PC <= PC+4, go to DECODE.
- DECODE:
  - Latch A = rs1, B = rs2 and the immediate.
  - Compute target = (PC-4)+imm into ALUOut.
  - jal: rd <= PC, PC <= target, retire, go to FETCH.
  - Otherwise go to EXEC.
- EXEC:
  - R/I ALU ops: ALUOut <= result, go to WB.
  - lw/sw: ALUOut <= A+imm, go to MEM.
  - beq/bne: if the condition holds, PC <= branch target. Then retire and go to FETCH.
- MEM:
  - mem_req = 1; mem_addr = ALUOut with [1:0] forced to 00; mem_we = 1 for sw, with mem_wdata = B.
  - Request is held until mem_ready.
  - sw: retire and go to FETCH.
  - lw: MDR <= mem_rdata, go to WB.
- WB:
  - rd <= ALUOut (or MDR for lw); retire; go to FETCH.
- Register x0:
  - Always reads 0; writes to x0 are discarded.
  - Writes occur only in DECODE(jal) or WB, on the clock edge.
- Retire: instret_o increments by 1 and wraps 2^32-1 -> 0.
- Latency with zero-wait memory (mem_ready high in the request cycle):

  | Instruction | Cycles |
  |---|---|
  | jal | 2 |
  | beq/bne | 3 |
  | R/I ALU, sw | 4 |
  | lw | 5 |

  Each memory wait cycle adds 1.
- Arithmetic:
  - 32-bit, wrap-around.
  - slt/slti compare signed.
  - Immediates are sign-extended per RV32I.
  - Branch/jal targets with bit 1 set are truncated to word alignment.
- Bus contract: mem_req never deasserts before mem_ready. mem_we and mem_addr do not change while mem_req = 1 and mem_ready = 0.

Optional Feature:
- Macro: RISCV_MC_HALT_ON_ILLEGAL_EN.
- Defined:
  - An illegal instruction in DECODE moves the FSM to HALT and sets halted_o = 1. The instruction is not retired.
  - PC stays at the faulting instruction address + 4, and the core issues no further requests.
  - Only reset exits HALT.
- Undefined:
  - An illegal instruction is a NOP: no register or memory write, retired, go to FETCH (2 cycles).
  - halted_o is tied to 0.

Test Plan:
- Basic ALU and cycle count: reset, zero-wait memory; program addi x1,x0,5; addi x2,x0,7; add x3,x1,x2; sub x4,x1,x2 -> x3 = 12, x4 = 0xFFFFFFFE; instret_o = 4 after 16 cycles.
- Load/store with waits: sw x3,8(x0) then lw x5,8(x0), with 3 wait cycles on every access -> mem write addr 8, data 12; x5 = 12; lw takes 11 cycles.
- Branch and jump: beq x1,x1,+8 skips the next instruction; bne x1,x1 is not taken; jal x6,+12 -> PC matches targets; x6 = address of jal + 4; x0 write via addi x0,x0,9 leaves x0 = 0.
- Async reset mid-access: assert reset while mem_req = 1 and mem_ready = 0 in MEM -> mem_req drops in the same cycle; pc_o = RESET_PC (test with RESET_PC = 32'h100); instret_o = 0.
- NUM_REGS = 16: add x17,x1,x2 is illegal. Macro defined -> halted_o = 1, no further mem_req. Macro undefined -> NOP, instret_o increments.
- Counter wrap: force instret to 32'hFFFFFFFF, retire 1 instruction -> instret_o = 0.
